telegram_scheduler: RTL and testbench
=====================================

// Module: telegram_scheduler
// PURPOSE
//  Sequences the telegram bit-timing generator for the door-handle HIL sim. Arbitrates
//  between host frame requests (UART command path) and a periodic auto-repeat source,
//  issues one start per frame, tracks repetitions, inserts inter-frame gaps and
//  supervises each frame with a timeout. Sits between the command decoder and the generator.
// PARAMETERS
//  GAP_CYCLES     1000   idle clk cycles between consecutive frames (>=1)
//  TIMEOUT_CYCLES 65535  max cycles from gen_start to gen_done before error (>=2)
//  PERIOD_W       16     width of auto_period
// PORTS
//  clk          in   1         system clock, rising edge
//  reset        in   1         reset, asynchronous, active-high
//  host_valid   in   1         host frame request; held until host_ready
//  host_ready   out  1         host request accepted this cycle
//  host_tele    in   8         telegram bits [6:0] (bit6=1 skips NFC bit), bit7 unused
//  host_reps    in   8         frames to send; 0 treated as 1
//  auto_en      in   1         enable periodic auto-repeat
//  auto_tele    in   8         telegram for auto frames
//  auto_period  in   PERIOD_W  cycles between auto-frame starts (0 = auto disabled)
//  abort        in   1         pulse: stop after current frame
//  gen_start    out  1         one-cycle pulse to generator
//  gen_tele     out  8         telegram held stable from gen_start to gen_done
//  gen_done     in   1         one-cycle pulse from generator at end of stop bit
//  busy         out  1         high in any state except IDLE
//  frames_sent  out  16        wrapping count of completed frames
//  timeout_err  out  1         sticky; cleared only by reset or accepted host request
// BEHAVIOUR
//  - Reset: state IDLE; host_ready=0, gen_start=0, gen_tele=0, busy=0, frames_sent=0,
//    timeout_err=0, rep counter=0, auto timer=0. Reset mid-frame abandons frame, no count.
//  - States: IDLE -> LOAD -> START -> WAIT_DONE -> GAP -> (START | IDLE).
//  - IDLE: if host_valid, host_ready=1 for one cycle, latch host_tele/host_reps (0->1),
//    clear timeout_err, goto LOAD. Else if auto request pending, latch auto_tele, reps=1,
//    goto LOAD. Host wins when both are pending the same cycle; auto stays pending.
//  - LOAD: drive gen_tele from latch (1 cycle). START: gen_start=1 one cycle -> WAIT_DONE.
//  - WAIT_DONE: on gen_done: frames_sent+1 (wrap FFFF->0), reps-1; goto GAP.
//    Timeout counter reaching TIMEOUT_CYCLES without gen_done: timeout_err=1, no count,
//    goto IDLE (remaining reps dropped).
//  - GAP: count GAP_CYCLES; then reps>0 and no abort latched -> START, else IDLE.
//  - Latency: host_ready to gen_start = 2 cycles; gen_done to next gen_start = GAP_CYCLES+1.
//  - abort: latched any time while busy, cleared on entering IDLE; current frame always
//    completes (never truncated). abort with gen_done same cycle: frame counted, then GAP->IDLE.
//    abort in IDLE ignored.
//  - Auto timer: free-runs while auto_en=1 and auto_period!=0, sets auto-pending every
//    auto_period cycles; timer and pending cleared when auto_en=0. Pending events do not
//    accumulate (max one). Host request arriving during an auto frame waits in IDLE.
//  - host_valid is not sampled while busy; host_ready only asserted in IDLE.
//  - gen_done outside WAIT_DONE is ignored.
// STRUCTURE
//  - Shared package hil_sched_pkg: state enum (IDLE,LOAD,START,WAIT_DONE,GAP), telegram
//    width 8, NFC-skip bit index 6, frames_sent width 16.
//  - One sub-module: sched_timer (loadable down-counter with done flag), instanced for
//    the gap/timeout counter (shared, reused per state) and the auto-period timer.
// TESTING
//  1 host_tele=0x15, host_reps=3, gen_done 200 cycles after each start -> 3 gen_start
//    pulses, gen_tele=0x15 throughout, frames_sent=3, busy drops after last GAP.
//  2 host_reps=0 -> exactly one frame; host_ready to gen_start = 2 cycles.
//  3 host_valid and auto pending same cycle in IDLE -> host frame first, auto frame
//    follows after GAP; frames_sent=2.
//  4 abort during frame 2 of 5 -> frame 2 completes, no frame 3, frames_sent=2, IDLE.
//  5 no gen_done with TIMEOUT_CYCLES=100 -> timeout_err=1 at cycle 100, IDLE, count
//    unchanged; next accepted host request clears timeout_err.
//  6 assert reset in WAIT_DONE -> all outputs zero same cycle; preset frames_sent=FFFF,
//    one frame -> wraps to 0.

Source files
------------

// File: rtl/hil_sched_pkg.sv
// Shared types and constants for the telegram scheduler and its timers.
package hil_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_DONE,
    GAP
  } state_e;

  localparam int unsigned TELE_W       = 8;
  localparam int unsigned NFC_SKIP_BIT = 6;
  localparam int unsigned FRAMES_W     = 16;
  localparam int unsigned REPS_W       = 8;

  function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

  function automatic logic skips_nfc(input logic [TELE_W-1:0] tele);
    return tele[NFC_SKIP_BIT];
  endfunction

endpackage

// File: rtl/telegram_scheduler_sched_timer.sv
// Loadable down-counter; done_o flags the last enabled cycle before reaching zero.
module sched_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         done_o
);

  logic [W-1:0] count_q, count_d;

  // An enabled counter sitting at zero reloads itself, which arms a free-running timer.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i || (en_i && (count_q == '0))) begin
      count_d = load_val_i;
    end else if (en_i) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = en_i && (count_q == W'(1));

endmodule

// File: rtl/telegram_scheduler.sv
// Frame scheduler: arbitrates host and auto-repeat requests, sequences gen_start,
// repetitions, inter-frame gaps and per-frame timeout for the telegram generator.
module telegram_scheduler
  import hil_sched_pkg::*;
#(
  parameter int unsigned GAP_CYCLES     = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned PERIOD_W       = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                host_valid,
  output logic                host_ready,
  input  logic [TELE_W-1:0]   host_tele,
  input  logic [REPS_W-1:0]   host_reps,
  input  logic                auto_en,
  input  logic [TELE_W-1:0]   auto_tele,
  input  logic [PERIOD_W-1:0] auto_period,
  input  logic                abort,
  output logic                gen_start,
  output logic [TELE_W-1:0]   gen_tele,
  input  logic                gen_done,
  output logic                busy,
  output logic [FRAMES_W-1:0] frames_sent,
  output logic                timeout_err
);

  localparam int unsigned CW = timer_width(GAP_CYCLES, TIMEOUT_CYCLES);

  state_e              state_q, state_d;
  logic [TELE_W-1:0]   tele_q, tele_d;
  logic [TELE_W-1:0]   gen_tele_q, gen_tele_d;
  logic [REPS_W-1:0]   reps_q, reps_d;
  logic [FRAMES_W-1:0] frames_q, frames_d;
  logic                terr_q, terr_d;
  logic                abort_q, abort_d;
  logic                auto_pend_q, auto_pend_d;
  logic                gen_start_q, busy_q;

  logic                tmr_load, tmr_en, tmr_done;
  logic [CW-1:0]       tmr_val;
  logic                auto_run, auto_done, auto_take;

  // One counter serves both the timeout (WAIT_DONE) and the gap (GAP); each state loads it on entry.
  sched_timer #(.W(CW)) u_frame_timer (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (1'b0),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .done_o     (tmr_done)
  );

  assign auto_run = auto_en && (auto_period != '0);

  sched_timer #(.W(PERIOD_W)) u_auto_timer (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (!auto_run),
    .load_i     (auto_done),
    .load_val_i (auto_period),
    .en_i       (auto_run),
    .done_o     (auto_done)
  );

  assign tmr_en = (state_q == WAIT_DONE) || (state_q == GAP);

  always_comb begin
    state_d    = state_q;
    tele_d     = tele_q;
    gen_tele_d = gen_tele_q;
    reps_d     = reps_q;
    frames_d   = frames_q;
    terr_d     = terr_q;
    abort_d    = abort_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    auto_take  = 1'b0;

    if ((state_q != IDLE) && abort) begin
      abort_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (host_valid) begin
          tele_d  = host_tele;
          reps_d  = (host_reps == '0) ? REPS_W'(1) : host_reps;
          terr_d  = 1'b0;
          state_d = LOAD;
        end else if (auto_pend_q) begin
          tele_d    = auto_tele;
          reps_d    = REPS_W'(1);
          auto_take = 1'b1;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        gen_tele_d = tele_q;
        state_d    = START;
      end
      START: begin
        tmr_load = 1'b1;
        tmr_val  = CW'(TIMEOUT_CYCLES - 1);
        state_d  = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (gen_done) begin
          frames_d = frames_q + FRAMES_W'(1);
          reps_d   = reps_q - REPS_W'(1);
          tmr_load = 1'b1;
          tmr_val  = CW'(GAP_CYCLES);
          state_d  = GAP;
        end else if (tmr_done) begin
          terr_d  = 1'b1;
          state_d = IDLE;
        end
      end
      GAP: begin
        if (tmr_done) begin
          state_d = ((reps_q != '0) && !(abort_q || abort)) ? START : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE) begin
      abort_d = 1'b0;
    end
  end

  assign auto_pend_d = auto_en ? (auto_done || (auto_pend_q && !auto_take)) : 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      tele_q      <= '0;
      gen_tele_q  <= '0;
      reps_q      <= '0;
      frames_q    <= '0;
      terr_q      <= 1'b0;
      abort_q     <= 1'b0;
      auto_pend_q <= 1'b0;
      gen_start_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tele_q      <= tele_d;
      gen_tele_q  <= gen_tele_d;
      reps_q      <= reps_d;
      frames_q    <= frames_d;
      terr_q      <= terr_d;
      abort_q     <= abort_d;
      auto_pend_q <= auto_pend_d;
      gen_start_q <= (state_d == START);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign host_ready  = (state_q == IDLE) && host_valid && !reset;
  assign gen_start   = gen_start_q;
  assign gen_tele    = gen_tele_q;
  assign busy        = busy_q;
  assign frames_sent = frames_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_telegram_scheduler.sv
// Scoreboard bench for telegram_scheduler with a behavioural generator responder.
module tb_telegram_scheduler;

  localparam int unsigned GAP = 5;
  localparam int unsigned TMO = 100;
  localparam int unsigned PW  = 16;
  localparam int          DLY = 60;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          host_valid = 1'b0;
  logic          host_ready;
  logic [7:0]    host_tele = '0;
  logic [7:0]    host_reps = '0;
  logic          auto_en = 1'b0;
  logic [7:0]    auto_tele = '0;
  logic [PW-1:0] auto_period = '0;
  logic          abort = 1'b0;
  logic          gen_start;
  logic [7:0]    gen_tele;
  logic          gen_done = 1'b0;
  logic          busy;
  logic [15:0]   frames_sent;
  logic          timeout_err;

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         done_dly = DLY;
  int         last_done = 0;
  int         ready_cyc = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];

  telegram_scheduler #(
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO),
    .PERIOD_W       (PW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .host_valid  (host_valid),
    .host_ready  (host_ready),
    .host_tele   (host_tele),
    .host_reps   (host_reps),
    .auto_en     (auto_en),
    .auto_tele   (auto_tele),
    .auto_period (auto_period),
    .abort       (abort),
    .gen_start   (gen_start),
    .gen_tele    (gen_tele),
    .gen_done    (gen_done),
    .busy        (busy),
    .frames_sent (frames_sent),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every gen_start must match the oldest expected telegram.
  initial begin : monitor
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!reset && gen_start) begin
        start_q.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL start_unexpected: gen_tele=%h with nothing expected (cycle %0d)", gen_tele, cyc);
        end else begin
          e = exp_q.pop_front();
          if (gen_tele !== e) begin
            errors++;
            $display("FAIL start_tele: got %h expected %h (cycle %0d)", gen_tele, e, cyc);
          end
        end
      end
    end
  end

  // Generator model: gen_done done_dly cycles after gen_start (0 = never answer).
  initial begin : responder
    int pend;
    logic [7:0] cur;
    pend = 0;
    cur  = '0;
    forever begin
      @(negedge clk);
      gen_done = 1'b0;
      if (reset) begin
        pend = 0;
      end else if (gen_start) begin
        cur  = gen_tele;
        pend = done_dly;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          gen_done  = 1'b1;
          last_done = cyc;
          checks++;
          if (gen_tele !== cur) begin
            errors++;
            $display("FAIL tele_stable: got %h expected %h at gen_done", gen_tele, cur);
          end
        end
      end
    end
  end

  task automatic host_send(input logic [7:0] t, input logic [7:0] r, input int n_exp);
    bit ok;
    for (int i = 0; i < n_exp; i++) exp_q.push_back(t);
    host_tele  = t;
    host_reps  = r;
    host_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      #1;
      if (host_ready) begin
        ok = 1'b1;
        ready_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    host_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL host_ready_wait: got no host_ready, expected one within 3000 cycles");
    end
  endtask

  task automatic wait_idle(output int idle_cyc);
    bit ok;
    ok = 1'b0;
    idle_cyc = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        idle_cyc = cyc;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL idle_wait: busy still 1, expected 0 within 5000 cycles");
    end
  endtask

  task automatic wait_starts(input int n);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (start_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL start_wait: got %0d starts, expected %0d", start_q.size(), n);
    end
  endtask

  task automatic test_reset();
    host_valid = 1'b1;
    #2;
    checks += 6;
    if (host_ready !== 1'b0) begin errors++; $display("FAIL rst_host_ready: got %b expected 0", host_ready); end
    if (gen_start !== 1'b0) begin errors++; $display("FAIL rst_gen_start: got %b expected 0", gen_start); end
    if (gen_tele !== 8'h00) begin errors++; $display("FAIL rst_gen_tele: got %h expected 00", gen_tele); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    if (frames_sent !== 16'h0000) begin errors++; $display("FAIL rst_frames: got %h expected 0000", frames_sent); end
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_terr: got %b expected 0", timeout_err); end
    host_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_repeats();
    int ic;
    start_q.delete();
    done_dly = DLY;
    host_send(8'h15, 8'd3, 3);
    wait_idle(ic);
    checks += 5;
    if (start_q.size() !== 3) begin
      errors++;
      $display("FAIL rep_starts: got %0d expected 3", start_q.size());
    end else begin
      if (start_q[1] - start_q[0] !== DLY + GAP + 1) begin errors++; $display("FAIL rep_spacing1: got %0d expected %0d", start_q[1] - start_q[0], DLY + GAP + 1); end
      if (start_q[2] - start_q[1] !== DLY + GAP + 1) begin errors++; $display("FAIL rep_spacing2: got %0d expected %0d", start_q[2] - start_q[1], DLY + GAP + 1); end
    end
    if (frames_sent !== 16'd3) begin errors++; $display("FAIL rep_frames: got %0d expected 3", frames_sent); end
    if (ic - last_done !== GAP + 1) begin errors++; $display("FAIL rep_busy_drop: got %0d expected %0d", ic - last_done, GAP + 1); end
  endtask

  task automatic test_zero_reps();
    int ic;
    start_q.delete();
    host_send(8'h5A, 8'd0, 1);
    wait_idle(ic);
    repeat (DLY + 10) @(negedge clk);
    checks += 2;
    if (start_q.size() !== 1) begin
      errors++;
      $display("FAIL zero_starts: got %0d expected 1", start_q.size());
    end else if (start_q[0] - ready_cyc !== 2) begin
      errors++;
      $display("FAIL zero_latency: got %0d expected 2", start_q[0] - ready_cyc);
    end
    if (frames_sent !== 16'd4) begin errors++; $display("FAIL zero_frames: got %0d expected 4", frames_sent); end
  endtask

  task automatic test_host_vs_auto();
    int a, ic;
    start_q.delete();
    auto_tele   = 8'h2A;
    auto_period = 16'd200;
    auto_en     = 1'b1;
    a = cyc;
    repeat (201) @(negedge clk);
    host_send(8'h33, 8'd1, 1);
    exp_q.push_back(8'h2A);
    wait_starts(2);
    wait_idle(ic);
    auto_en = 1'b0;
    checks += 4;
    if (ready_cyc - a !== 201) begin errors++; $display("FAIL arb_accept: got cycle +%0d expected +201", ready_cyc - a); end
    if (start_q.size() !== 2) begin
      errors++;
      $display("FAIL arb_starts: got %0d expected 2", start_q.size());
    end else if (start_q[1] - start_q[0] !== DLY + GAP + 3) begin
      errors++;
      $display("FAIL arb_spacing: got %0d expected %0d", start_q[1] - start_q[0], DLY + GAP + 3);
    end
    if (frames_sent !== 16'd6) begin errors++; $display("FAIL arb_frames: got %0d expected 6", frames_sent); end
    if (exp_q.size() !== 0) begin errors++; $display("FAIL arb_pending: got %0d unsent expected 0", exp_q.size()); end
  endtask

  task automatic test_abort();
    int ic;
    start_q.delete();
    host_send(8'h4C, 8'd5, 2);
    wait_starts(2);
    repeat (10) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_idle(ic);
    repeat (DLY + 20) @(negedge clk);
    checks += 3;
    if (start_q.size() !== 2) begin errors++; $display("FAIL abort_starts: got %0d expected 2", start_q.size()); end
    if (frames_sent !== 16'd8) begin errors++; $display("FAIL abort_frames: got %0d expected 8", frames_sent); end
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle: busy got %b expected 0", busy); end
    // abort while idle must not affect the next request
    start_q.delete();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    host_send(8'h11, 8'd2, 2);
    wait_idle(ic);
    checks += 2;
    if (start_q.size() !== 2) begin errors++; $display("FAIL abort_idle_starts: got %0d expected 2", start_q.size()); end
    if (frames_sent !== 16'd10) begin errors++; $display("FAIL abort_idle_frames: got %0d expected 10", frames_sent); end
  endtask

  task automatic test_timeout();
    int s, ic;
    start_q.delete();
    done_dly = 0;
    host_send(8'h07, 8'd2, 1);
    wait_starts(1);
    s = (start_q.size() > 0) ? start_q[0] : cyc;
    for (int i = 0; i < 300 && cyc < s + TMO - 1; i++) @(negedge clk);
    checks += 2;
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_early: timeout_err got %b expected 0", timeout_err); end
    if (busy !== 1'b1) begin errors++; $display("FAIL tmo_busy_early: got %b expected 1", busy); end
    @(negedge clk);
    checks += 3;
    if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_flag: got %b expected 1", timeout_err); end
    if (busy !== 1'b0) begin errors++; $display("FAIL tmo_idle: busy got %b expected 0", busy); end
    if (frames_sent !== 16'd10) begin errors++; $display("FAIL tmo_frames: got %0d expected 10", frames_sent); end
    repeat (20) @(negedge clk);
    checks += 1;
    if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b expected 1", timeout_err); end
    done_dly = DLY;
    host_send(8'h15, 8'd1, 1);
    checks += 1;
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_clear: got %b expected 0", timeout_err); end
    wait_idle(ic);
    checks += 1;
    if (frames_sent !== 16'd11) begin errors++; $display("FAIL tmo_after_frames: got %0d expected 11", frames_sent); end
  endtask

  task automatic test_reset_midframe_wrap();
    int ic;
    start_q.delete();
    done_dly = 0;
    host_send(8'h66, 8'd1, 1);
    wait_starts(1);
    repeat (10) @(negedge clk);
    host_valid = 1'b1;
    reset = 1'b1;
    #1;
    checks += 6;
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
    if (gen_start !== 1'b0) begin errors++; $display("FAIL mid_rst_start: got %b expected 0", gen_start); end
    if (gen_tele !== 8'h00) begin errors++; $display("FAIL mid_rst_tele: got %h expected 00", gen_tele); end
    if (frames_sent !== 16'h0000) begin errors++; $display("FAIL mid_rst_frames: got %h expected 0000", frames_sent); end
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL mid_rst_terr: got %b expected 0", timeout_err); end
    if (host_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b expected 0", host_ready); end
    host_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1 force dut.frames_q = 16'hFFFF;
    #1 release dut.frames_q;
    @(negedge clk);
    checks += 1;
    if (frames_sent !== 16'hFFFF) begin errors++; $display("FAIL wrap_preset: got %h expected FFFF", frames_sent); end
    done_dly = DLY;
    host_send(8'h15, 8'd1, 1);
    wait_idle(ic);
    checks += 1;
    if (frames_sent !== 16'h0000) begin errors++; $display("FAIL wrap_frames: got %h expected 0000", frames_sent); end
  endtask

  initial begin
    test_reset();
    test_repeats();
    test_zero_reps();
    test_host_vs_auto();
    test_abort();
    test_timeout();
    test_reset_midframe_wrap();
    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL leftover_expected: got %0d unsent frames expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation still running at 500000, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
